// File: rtl/risc_trace_tx.sv
// risc_trace_tx: commit-trace transmitter for the KGP-RISC core.
// Every cycle trace_valid is high, one retired-instruction record
// {instr_addr, instr, write_data} is pushed into a small FIFO. Records are
// sent on tx as 13 UART frames: a SYNC header byte, then the three words,
// each most-significant byte first. A frame is 1 start bit, 8 data bits
// (LSB first) and 1 stop bit, each bit lasting CLKS_PER_BIT cycles.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   trace_valid   record present this cycle
//   instr_addr    retired instruction address
//   instr         retired instruction word
//   write_data    write-back data
//   clr_overflow  clears the sticky overflow flag
//   tx            serial line, idle high (registered)
//   busy          transmitter not idle (registered)
//   fifo_count    records buffered
//   overflow      sticky: a record was dropped
//   drop_count    dropped records, saturating at 255; cleared only by reset
module risc_trace_tx #(
    parameter int         CLKS_PER_BIT = 4,
    parameter int         DEPTH        = 4,
    parameter logic [7:0] SYNC         = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_valid,
    input  logic [31:0]                instr_addr,
    input  logic [31:0]                instr,
    input  logic [31:0]                write_data,
    input  logic                       clr_overflow,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         state_q, state_d;
    logic [95:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     byte_q, byte_d;
    logic [95:0]    rec_q, rec_d;
    logic           tx_q, tx_d;
    logic           busy_q;
    logic           ovf_q, ovf_d;
    logic [7:0]     drop_q, drop_d;
    logic           pop, push, drop, baud_end;

    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    // A full FIFO still accepts a record when the head leaves the same cycle.
    assign push     = trace_valid && ((count_q != CW'(DEPTH)) || pop);
    assign drop     = trace_valid && !push;
    assign baud_end = (baud_q == BW'(CLKS_PER_BIT-1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        rec_d   = rec_q;
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = S_START;
                    rec_d   = mem_q[rd_ptr_q];
                    byte_d  = SYNC;
                    idx_d   = '0;
                end
            end
            S_START: if (baud_end) begin
                state_d = S_DATA;
                baud_d  = '0;
                bit_d   = '0;
            end
            S_DATA: if (baud_end) begin
                baud_d = '0;
                if (bit_q == 3'd7) begin
                    state_d = S_STOP;
                end else begin
                    bit_d  = bit_q + 3'd1;
                    byte_d = {1'b0, byte_q[7:1]};
                end
            end
            S_STOP: if (baud_end) begin
                baud_d = '0;
                if (idx_q != 4'd12) begin
                    // Next record byte comes from the top of the shift register.
                    state_d = S_START;
                    idx_d   = idx_q + 4'd1;
                    byte_d  = rec_q[95:88];
                    rec_d   = {rec_q[87:0], 8'h00};
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so it changes with the state.
        tx_d = 1'b1;
        if (state_d == S_START)     tx_d = 1'b0;
        else if (state_d == S_DATA) tx_d = byte_d[0];

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (clr_overflow) ovf_d = 1'b0;

        drop_d = drop_q;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            rec_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            rec_q    <= rec_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != S_IDLE);
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: only entries covered by the pointers are read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {instr_addr, instr, write_data};
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_risc_trace_tx.sv
// Testbench for risc_trace_tx: a record-level reference model (queue FIFO
// plus a per-record busy timer) and a UART line decoder check every cycle.
module tb_risc_trace_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int REC_CYCLES = 130 * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trace_valid = 1'b0;
    logic [31:0]   instr_addr = '0, instr = '0, write_data = '0;
    logic          clr_overflow = 1'b0;
    logic          tx, busy, overflow;
    logic [CW-1:0] fifo_count;
    logic [7:0]    drop_count;

    risc_trace_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .SYNC(8'hA5)) dut (
        .clk(clk), .rst(rst), .trace_valid(trace_valid),
        .instr_addr(instr_addr), .instr(instr), .write_data(write_data),
        .clr_overflow(clr_overflow), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [95:0] m_fifo[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          m_timer = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    bit          m_pop, m_acc;
    logic [95:0] m_rec;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fifo.delete(); exp_q.delete();
            m_timer = 0; m_ovf = 0; m_drop = 0;
        end else begin
            m_pop = (m_timer == 0) && (m_fifo.size() > 0);
            m_acc = trace_valid && ((m_fifo.size() < DEPTH) || m_pop);
            if (m_timer > 0) m_timer--;
            if (m_pop) begin
                m_rec = m_fifo.pop_front();
                m_timer = REC_CYCLES;
                exp_q.push_back(8'hA5);
                for (int b = 11; b >= 0; b--) exp_q.push_back(m_rec[b*8 +: 8]);
            end
            if (m_acc) m_fifo.push_back({instr_addr, instr, write_data});
            if (trace_valid && !m_acc) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end else if (clr_overflow) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk("busy", 32'(busy), 32'(m_timer != 0));
            chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_count", 32'(drop_count), 32'(m_drop));
            if (m_timer == 0) chk("tx_idle", 32'(tx), 32'd1);
        end
    end

    // ---------------- UART decoder ----------------
    bit       d_act = 0;
    int       d_off = 0;
    logic [7:0] d_byte;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            d_act = 0; d_off = 0; rx_q.delete();
        end else if (chk_en) begin
            if (!d_act) begin
                if (tx == 1'b0) begin d_act = 1; d_off = 0; end
            end else d_off++;
            if (d_act) begin
                if (d_off == CPB/2) chk("start_bit", 32'(tx), 32'd0);
                if (d_off >= CPB + CPB/2 && d_off <= 8*CPB + CPB/2 && ((d_off - CPB/2) % CPB) == 0)
                    d_byte[(d_off - CPB/2)/CPB - 1] = tx;
                if (d_off == 9*CPB + CPB/2) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(d_byte);
                    d_act = 0;
                end
            end
        end
    end

    task automatic check_rx();
        logic [7:0] r;
        while (rx_q.size() > 0) begin
            r = rx_q.pop_front();
            if (exp_q.size() == 0) chk("rx_extra_byte", 32'(r), 32'hFFFF_FFFF);
            else chk("rx_byte", 32'(r), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic drain(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (m_fifo.size() == 0 && m_timer == 0) break;
        end
        chk("drain_timeout", 32'(i < limit), 32'd1);
        repeat (4) @(negedge clk);
        check_rx();
        chk("rx_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drive(input bit v, input bit clr, input logic [31:0] a,
                         input logic [31:0] ins, input logic [31:0] d);
        trace_valid = v; clr_overflow = clr; instr_addr = a; instr = ins; write_data = d;
    endtask

    task automatic check_reset_vals();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
    endtask

    typedef struct {
        bit v; bit clr;
        int e_cnt; int e_busy; int e_ovf; int e_drop;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] single_exp [13];
    int         bcnt, i, dbefore;

    initial begin
        tbl[0] = '{1, 0, 1, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 1, 0, 0};
        tbl[2] = '{1, 0, 2, 1, 0, 0};
        tbl[3] = '{1, 0, 3, 1, 0, 0};
        tbl[4] = '{1, 0, 4, 1, 0, 0};
        tbl[5] = '{1, 0, 4, 1, 1, 1};
        tbl[6] = '{1, 1, 4, 1, 1, 2};  // drop beats clear
        tbl[7] = '{0, 1, 4, 1, 0, 2};
        tbl[8] = '{0, 0, 4, 1, 0, 2};
        single_exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34,
                       8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        // Reset
        #7 rst = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); rst = 1'b1; chk_en = 1;

        // Single record: latency, duration and byte stream
        drive(1, 0, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        chk("lat_count_push", 32'(fifo_count), 32'd1);
        chk("lat_busy_push", 32'(busy), 32'd0);
        @(negedge clk);
        chk("lat_count_pop", 32'(fifo_count), 32'd0);
        chk("lat_busy_pop", 32'(busy), 32'd1);
        chk("lat_tx_start", 32'(tx), 32'd0);
        bcnt = 1;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) bcnt++; else break;
        end
        chk("busy_cycles", 32'(bcnt), 32'(REC_CYCLES));
        repeat (2) @(negedge clk);
        chk("single_nbytes", 32'(rx_q.size()), 32'd13);
        for (int k = 0; k < 13; k++)
            if (k < rx_q.size()) chk("single_byte", 32'(rx_q[k]), 32'(single_exp[k]));
        check_rx();

        // Overflow table from empty
        for (int k = 0; k < 9; k++) begin
            drive(tbl[k].v, tbl[k].clr, 32'h100 + 32'(k*4), $urandom, $urandom);
            @(negedge clk);
            chk("tbl_count", 32'(fifo_count), 32'(tbl[k].e_cnt));
            chk("tbl_busy", 32'(busy), 32'(tbl[k].e_busy));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[k].e_ovf));
            chk("tbl_drop", 32'(drop_count), 32'(tbl[k].e_drop));
        end
        drive(0, 0, 0, 0, 0);
        drain(5000);

        // Push accepted on the pop cycle while full
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, $urandom, $urandom, $urandom);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("wait_idle_timeout", 32'(i < 1000), 32'd1);
        dbefore = m_drop;
        drive(1, 0, $urandom, $urandom, $urandom);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        chk("popcycle_count", 32'(fifo_count), 32'd4);
        chk("popcycle_busy", 32'(busy), 32'd1);
        chk("popcycle_drop", 32'(drop_count), 32'(dbefore));

        // Saturation
        for (int k = 0; k < 300; k++) begin
            drive(1, 0, $urandom, $urandom, $urandom);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        chk("sat_drop", 32'(drop_count), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);
        drive(0, 1, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        drain(5000);

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 31) == 0,
                  $urandom, $urandom, $urandom);
            @(negedge clk);
            check_rx();
        end
        drive(0, 0, 0, 0, 0);
        drain(6000);

        // Reset during DATA of byte 5
        drive(1, 0, 32'hCAFE_0000, 32'h0BAD_F00D, 32'h1357_9BDF);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        @(negedge clk);
        repeat (5*10*CPB + CPB + 10) @(negedge clk);
        check_rx();
        #2 rst = 1'b0;
        #1 check_reset_vals();
        @(negedge clk); rst = 1'b1;
        drive(1, 0, 32'h0000_0008, 32'hFFFF_0000, 32'h0F0F_0F0F);
        @(negedge clk); drive(0, 0, 0, 0, 0);
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_q.size() > 0) break;
        end
        chk("post_rst_rx_timeout", 32'(rx_q.size() > 0), 32'd1);
        if (rx_q.size() > 0) chk("post_rst_sync", 32'(rx_q[0]), 32'hA5);
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
